// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SWHOLD  = 2'd3
    } seq_state_e;

    // One counter serves both the stage spacing and the warm-reset hold.
    function automatic int cnt_width(input int stage_delay, input int sw_hold);
        int longest;
        longest = (stage_delay > sw_hold) ? stage_delay : sw_hold;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

    function automatic int idx_width(input int num_stages);
        return (num_stages > 1) ? $clog2(num_stages) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts SYNC_STAGES edges
// after rst_n rises.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic srst_n
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign srst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: releases NUM_STAGES reset domains in order,
// STAGE_DELAY cycles apart, and runs software-requested warm resets.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_RESET   | all stages held, waiting for synchronized deassertion
//   ST_RELEASE | releasing stages one by one, stage 0 first
//   ST_RUN     | all stages released, warm-reset requests accepted
//   ST_SWHOLD  | warm reset: all stages held for SW_HOLD cycles
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SW_HOLD     = 16
) (
    input  logic                  clk,
    input  logic                  async_rstn,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  seq_done,
    output logic                  sw_rst_ack,
    output logic [1:0]            state
);

    localparam int CW = cnt_width(STAGE_DELAY, SW_HOLD);
    localparam int IW = idx_width(NUM_STAGES);

    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(SW_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_STAGES - 1);

    logic srst_n;

    seq_state_e            state_q,    state_d;
    logic [CW-1:0]         cnt_q,      cnt_d;
    logic [IW-1:0]         idx_q,      idx_d;
    logic                  sw_flag_q,  sw_flag_d;
    logic [NUM_STAGES-1:0] rst_out_q,  rst_out_d;
    logic                  seq_done_q, seq_done_d;
    logic                  sw_ack_q,   sw_ack_d;

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk   (clk),
        .rst_n (async_rstn),
        .srst_n(srst_n)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sw_flag_d  = sw_flag_q;
        rst_out_d  = rst_out_q;
        seq_done_d = seq_done_q;
        sw_ack_d   = 1'b0;

        case (state_q)
            ST_RESET: begin
                if (srst_n) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            ST_RELEASE: begin
                if (cnt_q == STAGE_LAST) begin
                    rst_out_d = rst_out_q | (NUM_STAGES'(1) << idx_q);
                    cnt_d     = '0;
                    idx_d     = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        // Last stage out: ack only if this was a warm reset.
                        state_d    = ST_RUN;
                        idx_d      = '0;
                        seq_done_d = 1'b1;
                        sw_ack_d   = sw_flag_q;
                        sw_flag_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RUN: begin
                if (sw_rst_req) begin
                    state_d    = ST_SWHOLD;
                    rst_out_d  = '0;
                    seq_done_d = 1'b0;
                    sw_flag_d  = 1'b1;
                    cnt_d      = '0;
                end
            end

            ST_SWHOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or negedge async_rstn) begin
        if (!async_rstn) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            idx_q      <= '0;
            sw_flag_q  <= 1'b0;
            rst_out_q  <= '0;
            seq_done_q <= 1'b0;
            sw_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sw_flag_q  <= sw_flag_d;
            rst_out_q  <= rst_out_d;
            seq_done_q <= seq_done_d;
            sw_ack_q   <= sw_ack_d;
        end
    end

    assign rst_out_n  = rst_out_q;
    assign seq_done   = seq_done_q;
    assign sw_rst_ack = sw_ack_q;
    assign state      = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default build plus a minimum-parameter
// corner build sharing clock and board reset.
module tb_reset_sequencer;

    localparam int NS = 4;
    localparam int SD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          async_rstn;
    logic          sw_rst_req;
    logic          sw_rst_req_c;
    logic [NS-1:0] rst_out_n;
    logic          seq_done;
    logic          sw_rst_ack;
    logic [1:0]    state;
    logic [0:0]    rst_out_n_c;
    logic          seq_done_c;
    logic          sw_rst_ack_c;
    logic [1:0]    state_c;

    int n_cmp = 0;
    int n_bad = 0;

    reset_sequencer #(
        .NUM_STAGES(4), .STAGE_DELAY(8), .SYNC_STAGES(2), .SW_HOLD(16)
    ) u_dut (
        .clk       (clk),
        .async_rstn(async_rstn),
        .sw_rst_req(sw_rst_req),
        .rst_out_n (rst_out_n),
        .seq_done  (seq_done),
        .sw_rst_ack(sw_rst_ack),
        .state     (state)
    );

    reset_sequencer #(
        .NUM_STAGES(1), .STAGE_DELAY(1), .SYNC_STAGES(2), .SW_HOLD(1)
    ) u_dut_c (
        .clk       (clk),
        .async_rstn(async_rstn),
        .sw_rst_req(sw_rst_req_c),
        .rst_out_n (rst_out_n_c),
        .seq_done  (seq_done_c),
        .sw_rst_ack(sw_rst_ack_c),
        .state     (state_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stage k is released first_edge + k*SD edges after the reference edge.
    function automatic logic [NS-1:0] exp_stages(input int m, input int first_edge);
        logic [NS-1:0] r;
        r = '0;
        for (int k = 0; k < NS; k++)
            if (m >= first_edge + SD * k) r[k] = 1'b1;
        return r;
    endfunction

    // Called just after async_rstn rises, between edges.
    task automatic run_por(input string tag);
        int acks;
        acks = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (sw_rst_ack) acks++;
            check({tag, "_rst"}, rst_out_n, exp_stages(n, 11));
            check({tag, "_done"}, seq_done, (n >= 35));
            check({tag, "_state"}, state, (n < 3) ? 0 : ((n < 35) ? 1 : 2));
            check({tag, "_cor_rst"}, rst_out_n_c, (n >= 4));
            check({tag, "_cor_done"}, seq_done_c, (n >= 4));
        end
        check({tag, "_acks"}, acks, 0);
    endtask

    // Warm-reset window after the request edge E; ack expected at m==48.
    task automatic warm_window(input string tag, output int acks);
        acks = 0;
        for (int m = 1; m <= 48; m++) begin
            tick();
            if (sw_rst_ack) acks++;
            check({tag, "_rst"}, rst_out_n, exp_stages(m, 24));
            check({tag, "_ack"}, sw_rst_ack, (m == 48));
            check({tag, "_done"}, seq_done, (m >= 48));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        int acks2;

        async_rstn   = 1'b0;
        sw_rst_req   = 1'b0;
        sw_rst_req_c = 1'b0;
        repeat (5) tick();
        check("rst_out", rst_out_n, 0);
        check("rst_done", seq_done, 0);
        check("rst_ack", sw_rst_ack, 0);
        check("rst_state", state, 0);
        check("rst_cor", rst_out_n_c, 0);

        async_rstn = 1'b1;
        run_por("por");

        // Single-cycle warm reset from ST_RUN.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        check("warm_e_rst", rst_out_n, 0);
        check("warm_e_state", state, 3);
        check("warm_e_done", seq_done, 0);
        warm_window("warm", acks);
        check("warm_acks", acks, 1);
        tick();
        check("warm_ack_clr", sw_rst_ack, 0);
        check("warm_run", state, 2);

        // Request held high throughout: ignored until ST_RUN, then re-armed.
        sw_rst_req = 1'b1;
        tick();
        check("drop_e_state", state, 3);
        warm_window("drop1", acks);
        tick();
        check("drop_rearm_state", state, 3);
        check("drop_rearm_rst", rst_out_n, 0);
        check("drop_rearm_ack", sw_rst_ack, 0);
        sw_rst_req = 1'b0;
        warm_window("drop2", acks2);
        check("drop_acks", acks + acks2, 2);
        tick();

        // Asynchronous assertion in ST_RUN, between edges.
        #3;
        async_rstn = 1'b0;
        #1;
        check("async_rst", rst_out_n, 0);
        check("async_done", seq_done, 0);
        check("async_state", state, 0);
        check("async_cor", rst_out_n_c, 0);
        tick();
        tick();
        async_rstn = 1'b1;
        run_por("por2");

        // Abort a warm reset after stage 1 is out; the flag must not survive.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        repeat (32) tick();
        check("abort_pre", rst_out_n, 4'b0011);
        #3;
        async_rstn = 1'b0;
        #1;
        check("abort_rst", rst_out_n, 0);
        check("abort_ack", sw_rst_ack, 0);
        check("abort_state", state, 0);
        repeat (3) tick();
        async_rstn = 1'b1;
        run_por("por3");

        // Corner build: warm reset completes two edges after the request.
        sw_rst_req_c = 1'b1;
        tick();
        sw_rst_req_c = 1'b0;
        check("cor_w0_rst", rst_out_n_c, 0);
        check("cor_w0_state", state_c, 3);
        tick();
        check("cor_w1_rst", rst_out_n_c, 0);
        check("cor_w1_state", state_c, 1);
        tick();
        check("cor_w2_rst", rst_out_n_c, 1);
        check("cor_w2_ack", sw_rst_ack_c, 1);
        check("cor_w2_done", seq_done_c, 1);
        tick();
        check("cor_w3_ack", sw_rst_ack_c, 0);
        check("cor_w3_state", state_c, 2);
        check("idle_main", rst_out_n, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
